mem_port_arbiter: RTL

Sequences the single-port unified instruction/data memory for the pipelined MIPS core. It arbitrates between instruction fetch (IF stage, read-only) and data access (MEM stage, load/store) and drives the RAM for a fixed multi-cycle latency. It returns a one-cycle ready pulse to the served requester. It exports per-stage stall signals that feed the hazard/stall logic alongside the load-use, jump and branch stalls.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   localparam int unsigned DEF_LAT = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer arbitrating IF fetches against MEM loads/stores.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed MEM-over-IF priority.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned LAT = DEF_LAT,
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          mem_rd,
   input  logic          mem_wr,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_rdata,
   output logic          mem_ready,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          stall_if,
   output logic          stall_mem
);

   localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

   state_t        state, state_n;
   logic          owner;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          we_q;
   logic          flush_q;
   logic          if_ready_q, mem_ready_q;
   logic [DW-1:0] if_rdata_q, mem_rdata_q;
   logic          cnt_zero;
   logic          grant;
   logic          grant_own;
   logic          pick;
   logic          if_v, mem_v;

   assign if_v  = if_req & ~if_flush;
   assign mem_v = mem_rd | mem_wr;

`ifdef MEM_ARB_RR_EN
   logic rr_last;

   // On contention the requester not served last wins; a lone requester always wins.
   always_comb begin
      if (if_v && mem_v) pick = (rr_last == OWN_MEM) ? OWN_IF : OWN_MEM;
      else               pick = mem_v ? OWN_MEM : OWN_IF;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rr_last <= OWN_IF;
      else if (grant) rr_last <= grant_own;
   end
`else
   assign pick = mem_v ? OWN_MEM : OWN_IF;
`endif

   generate
      if (LAT > 1) begin : g_cnt
         logic [CW-1:0] cnt;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)                              cnt <= '0;
            else if (grant)                          cnt <= CW'(LAT - 1);
            else if (state == ACCESS && cnt != '0)   cnt <= cnt - 1'b1;
         end
         assign cnt_zero = (cnt == '0);
      end else begin : g_nocnt
         assign cnt_zero = 1'b1;
      end
   endgenerate

   always_comb begin
      state_n   = state;
      grant     = 1'b0;
      grant_own = OWN_MEM;
      case (state)
         IDLE: begin
            if (if_v || mem_v) begin
               grant     = 1'b1;
               grant_own = pick;
               state_n   = ACCESS;
            end
         end
         ACCESS:  if (cnt_zero) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= OWN_MEM;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         flush_q     <= 1'b0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state       <= state_n;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         if (grant) begin
            owner   <= grant_own;
            we_q    <= (grant_own == OWN_MEM) & mem_wr;
            addr_q  <= (grant_own == OWN_MEM) ? mem_addr : if_addr;
            wdata_q <= (grant_own == OWN_MEM) ? mem_wdata : '0;
            flush_q <= 1'b0;
         end
         if (state == ACCESS) begin
            if (owner == OWN_IF && if_flush) flush_q <= 1'b1;
            // A flush in the final access cycle must also suppress the pulse.
            if (cnt_zero) begin
               if (owner == OWN_IF) begin
                  if_rdata_q <= ram_rdata;
                  if_ready_q <= ~(flush_q | if_flush);
               end else begin
                  mem_rdata_q <= ram_rdata;
                  mem_ready_q <= 1'b1;
               end
            end
         end
      end
   end

   assign ram_en    = (state == ACCESS);
   assign ram_we    = ram_en & we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

   assign if_ready  = if_ready_q;
   assign mem_ready = mem_ready_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;

   assign stall_if  = if_req & ~if_ready_q;
   assign stall_mem = mem_v & ~mem_ready_q;

endmodule
